// File: rtl/mult_acc_pkg.sv
// Shared types and arithmetic for the multiply-accumulate stage.
// Holds the FSM state encoding, the product width and the add step
// used by the datapath (wrapping or saturating, chosen by the caller).
package mult_acc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam int PROD_W    = 8;
    // Widest accumulator the add step supports; ACC_W must lie in [PROD_W, MAX_ACC_W].
    localparam int MAX_ACC_W = 32;

    typedef struct packed {
        logic                 carry;
        logic [MAX_ACC_W-1:0] sum;
    } step_t;

    // One accumulation step at a run-time width: returns the carry out of
    // bit width-1 and the new sum, wrapped to width bits or clamped to all
    // ones when sat is set and the add carried.
    function automatic step_t acc_step(input logic [MAX_ACC_W-1:0] acc,
                                       input logic [PROD_W-1:0]    prod,
                                       input logic [5:0]           width,
                                       input logic                 sat);
        logic [MAX_ACC_W:0] full;
        logic [MAX_ACC_W:0] one;
        logic [MAX_ACC_W:0] mask;
        step_t              r;
        one  = (MAX_ACC_W + 1)'(1);
        full = {1'b0, acc} + (MAX_ACC_W + 1)'(prod);
        mask = (one << width) - one;
        // acc < 2^width and prod <= 2^width - 1, so bit 'width' is the carry.
        r.carry = full[width];
        r.sum   = MAX_ACC_W'(full & mask);
        if (sat && r.carry) begin
            r.sum = MAX_ACC_W'(mask);
        end
        return r;
    endfunction

endpackage

// File: rtl/mult_acc_stage_if.sv
// Beat-in / sum-out bus of the multiply-accumulate stage.
// Handshake: a beat moves when in_valid && in_ready on a rising edge, a
// result moves when out_valid && out_ready on a rising edge; the producer
// holds valid and its payload stable until the transfer, and the consumer
// may raise or drop ready freely.
interface mult_acc_stage_if #(
    parameter int ACC_W     = 16,
    parameter int MAX_TERMS = 16
);
    localparam int CNT_W = $clog2(MAX_TERMS + 1);

    logic                             in_valid;
    logic                             in_ready;
    logic [mult_acc_pkg::PROD_W-1:0]  prod;
    logic                             in_last;
    logic                             out_valid;
    logic                             out_ready;
    logic [ACC_W-1:0]                 out_sum;
    logic [CNT_W-1:0]                 out_count;
    logic                             out_ovf;

    modport master (
        output in_valid, prod, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_count, out_ovf
    );

    modport slave (
        input  in_valid, prod, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_count, out_ovf
    );

endinterface

// File: rtl/mult_acc_datapath.sv
// Accumulator, beat counter and sticky overflow flag.
// Define MULT_ACC_SAT_EN to clamp the sum at all ones on overflow;
// otherwise the sum wraps modulo 2^ACC_W.
module mult_acc_datapath
    import mult_acc_pkg::*;
#(
    parameter int ACC_W = 16,
    parameter int CNT_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,   // first beat of a transaction
    input  logic              add,    // any later beat
    input  logic              clear,  // result handed downstream
    input  logic [PROD_W-1:0] prod,
    output logic [ACC_W-1:0]  acc,
    output logic [CNT_W-1:0]  cnt,
    output logic              ovf
);

`ifdef MULT_ACC_SAT_EN
    localparam logic SAT = 1'b1;
`else
    localparam logic SAT = 1'b0;
`endif

    step_t step;

    // Next sum and carry for the beat on prod.
    always_comb step = acc_step(MAX_ACC_W'(acc), prod, 6'(ACC_W), SAT);

    // Sum bits above ACC_W are always zero by construction.
    if (ACC_W < MAX_ACC_W) begin : g_hi
        logic unused_hi;
        assign unused_hi = ^step.sum[MAX_ACC_W-1:ACC_W];
    end

    // Registers: first beat loads, later beats add, result handoff clears.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            acc <= '0;
            cnt <= '0;
            ovf <= 1'b0;
        end else if (load) begin
            acc <= ACC_W'(prod);
            cnt <= CNT_W'(1);
            ovf <= 1'b0;
        end else if (add) begin
            acc <= step.sum[ACC_W-1:0];
            cnt <= cnt + CNT_W'(1);
            ovf <= ovf | step.carry;
        end
    end

endmodule

// File: rtl/mult_acc_stage.sv
// Multiply-accumulate stage: sums 8-bit products per transaction and
// presents one registered result per transaction. A transaction closes on
// in_last or after MAX_TERMS beats. MULT_ACC_SAT_EN selects saturating
// accumulation (see mult_acc_datapath). dbg_state mirrors the FSM state.
module mult_acc_stage
    import mult_acc_pkg::*;
#(
    parameter int ACC_W     = 16,
    parameter int MAX_TERMS = 16
) (
    input  logic              clk,
    input  logic              rst,
    mult_acc_stage_if.slave   bus,
    output state_t            dbg_state
);

    localparam int CNT_W = $clog2(MAX_TERMS + 1);

    state_t           state;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             accept;
    logic             out_fire;
    logic             close_beat;
    logic             load;
    logic             add;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             ovf;

    // Handshake decode and the "this beat closes the transaction" test.
    always_comb begin
        accept   = bus.in_valid && in_ready_q;
        out_fire = out_valid_q && bus.out_ready;
        load     = accept && (state == IDLE);
        add      = accept && (state == ACCUM);
        if (state == IDLE) begin
            close_beat = bus.in_last || (MAX_TERMS == 1);
        end else begin
            close_beat = bus.in_last || ((int'(cnt) + 1) == MAX_TERMS);
        end
    end

    // FSM with registered in_ready/out_valid; in_ready is low for all of HOLD.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE, ACCUM: begin
                    if (accept) begin
                        if (close_beat) begin
                            state       <= HOLD;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end
                HOLD: begin
                    if (out_fire) begin
                        state       <= IDLE;
                        in_ready_q  <= 1'b1;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    mult_acc_datapath #(
        .ACC_W (ACC_W),
        .CNT_W (CNT_W)
    ) u_datapath (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .add   (add),
        .clear (out_fire),
        .prod  (bus.prod),
        .acc   (acc),
        .cnt   (cnt),
        .ovf   (ovf)
    );

    // The datapath registers are the result registers; they hold in HOLD.
    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sum   = acc;
    assign bus.out_count = cnt;
    assign bus.out_ovf   = ovf;
    assign dbg_state     = state;

endmodule

// File: tb/tb_mult_acc_stage.sv
// Bench for mult_acc_stage: DUT 0 uses defaults (ACC_W=16, MAX_TERMS=16),
// DUT 1 uses ACC_W=8, MAX_TERMS=4 for overflow and early-close cases.
// Honors MULT_ACC_SAT_EN for expected overflow behaviour.
module tb_mult_acc_stage;
    import mult_acc_pkg::*;

`ifdef MULT_ACC_SAT_EN
    localparam bit SAT_MODEL = 1'b1;
`else
    localparam bit SAT_MODEL = 1'b0;
`endif
    localparam int EW = 22;  // {ovf, count[4:0], sum[15:0]}

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst;
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- DUTs ----------------
    mult_acc_stage_if #(.ACC_W(16), .MAX_TERMS(16)) ifa ();
    mult_acc_stage_if #(.ACC_W(8),  .MAX_TERMS(4))  ifb ();
    state_t dbg0;
    state_t dbg1;

    mult_acc_stage #(.ACC_W(16), .MAX_TERMS(16)) dut0 (
        .clk(clk), .rst(rst), .bus(ifa.slave), .dbg_state(dbg0));
    mult_acc_stage #(.ACC_W(8), .MAX_TERMS(4)) dut1 (
        .clk(clk), .rst(rst), .bus(ifb.slave), .dbg_state(dbg1));

    logic        iv[2];
    logic        il[2];
    logic        ordy[2];
    logic [7:0]  pr[2];
    logic        ir[2];
    logic        ov[2];
    logic [15:0] osum[2];
    logic [4:0]  ocnt[2];
    logic        oovf[2];

    assign ifa.in_valid  = iv[0];
    assign ifa.in_last   = il[0];
    assign ifa.prod      = pr[0];
    assign ifa.out_ready = ordy[0];
    assign ifb.in_valid  = iv[1];
    assign ifb.in_last   = il[1];
    assign ifb.prod      = pr[1];
    assign ifb.out_ready = ordy[1];
    assign ir[0]   = ifa.in_ready;
    assign ov[0]   = ifa.out_valid;
    assign osum[0] = ifa.out_sum;
    assign ocnt[0] = ifa.out_count;
    assign oovf[0] = ifa.out_ovf;
    assign ir[1]   = ifb.in_ready;
    assign ov[1]   = ifb.out_valid;
    assign osum[1] = 16'(ifb.out_sum);
    assign ocnt[1] = 5'(ifb.out_count);
    assign oovf[1] = ifb.out_ovf;

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- reference model / scoreboard ----------------
    // Tracks the beats of the open transaction and queues the expected
    // result when it closes; results are compared on the output handshake.
    logic [EW-1:0] exp_q0[$];
    logic [EW-1:0] exp_q1[$];
    longint        cur_tot[2];
    int            cur_n[2];

    function automatic logic [EW-1:0] expect_result(input int d, input longint tot, input int n);
        longint lim;
        longint s;
        bit     o;
        lim = (d == 0) ? (64'd1 << 16) : (64'd1 << 8);
        o   = (tot >= lim);
        if (SAT_MODEL) s = o ? (lim - 1) : tot;
        else           s = tot % lim;
        return {o, 5'(n), 16'(s)};
    endfunction

    task automatic mon(input int d);
        int            qs;
        int            maxt;
        logic [EW-1:0] e;
        maxt = (d == 0) ? 16 : 4;
        if (rst) begin
            cur_tot[d] = 0;
            cur_n[d]   = 0;
            if (d == 0) exp_q0.delete();
            else        exp_q1.delete();
            return;
        end
        qs = (d == 0) ? exp_q0.size() : exp_q1.size();
        check($sformatf("sb_in_ready_d%0d", d), ir[d], (qs == 0));
        check($sformatf("sb_out_valid_d%0d", d), ov[d], (qs != 0));
        if (ov[d] && ordy[d] && qs != 0) begin
            if (d == 0) e = exp_q0.pop_front();
            else        e = exp_q1.pop_front();
            check($sformatf("sb_result_d%0d", d), {oovf[d], ocnt[d], osum[d]}, e);
        end
        if (iv[d] && ir[d]) begin
            cur_tot[d] += longint'(pr[d]);
            cur_n[d]++;
            if (il[d] || cur_n[d] == maxt) begin
                e = expect_result(d, cur_tot[d], cur_n[d]);
                if (d == 0) exp_q0.push_back(e);
                else        exp_q1.push_back(e);
                cur_tot[d] = 0;
                cur_n[d]   = 0;
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0);
        mon(1);
    end

    // ---------------- driver tasks ----------------
    task automatic send_beat(input int d, input logic [7:0] p, input logic l);
        int n;
        bit a;
        n = 0;
        a = 1'b0;
        iv[d] = 1'b1;
        pr[d] = p;
        il[d] = l;
        while (!a && n < 50) begin
            @(negedge clk);
            a = ir[d];
            @(posedge clk);
            #1;
            n++;
        end
        iv[d] = 1'b0;
        il[d] = 1'b0;
        if (!a) check("send_timeout", 0, 1);
    endtask

    task automatic wait_out(input int d, output logic [15:0] s, output logic [4:0] c,
                            output logic o);
        int n;
        bit got;
        n   = 0;
        got = 1'b0;
        s   = '0;
        c   = '0;
        o   = 1'b0;
        ordy[d] = 1'b1;
        while (!got && n < 40) begin
            @(negedge clk);
            if (ov[d]) begin
                got = 1'b1;
                s   = osum[d];
                c   = ocnt[d];
                o   = oovf[d];
            end
            @(posedge clk);
            #1;
            n++;
        end
        ordy[d] = 1'b0;
        check("out_timeout", got, 1);
    endtask

    task automatic expect_out(input int d, input string name, input longint es,
                              input longint ec, input longint eo);
        logic [15:0] s;
        logic [4:0]  c;
        logic        o;
        wait_out(d, s, c, o);
        check({name, "_sum"}, s, es);
        check({name, "_count"}, c, ec);
        check({name, "_ovf"}, o, eo);
    endtask

    // ---------------- vector table ----------------
    typedef struct packed {
        logic [2:0]      n;
        logic [3:0][7:0] p;    // p[0] is the first beat
        logic [15:0]     sum;
        logic [4:0]      cnt;
        logic            ovf;
    } vec_t;
    localparam int NV = 6;
    vec_t vt[NV];

    // ---------------- test sequence ----------------
    initial begin
        bit spurious;
        bit a;
        for (int d = 0; d < 2; d++) begin
            iv[d] = 1'b0; il[d] = 1'b0; ordy[d] = 1'b0; pr[d] = '0;
            cur_tot[d] = 0; cur_n[d] = 0;
        end
        vt[0] = '{n: 3'd3, p: {8'd0,   8'd225, 8'd225, 8'd225}, sum: 16'd675,  cnt: 5'd3, ovf: 1'b0};
        vt[1] = '{n: 3'd1, p: {8'd0,   8'd0,   8'd0,   8'd0},   sum: 16'd0,    cnt: 5'd1, ovf: 1'b0};
        vt[2] = '{n: 3'd1, p: {8'd0,   8'd0,   8'd0,   8'd255}, sum: 16'd255,  cnt: 5'd1, ovf: 1'b0};
        vt[3] = '{n: 3'd4, p: {8'd5,   8'd0,   8'd0,   8'd0},   sum: 16'd5,    cnt: 5'd4, ovf: 1'b0};
        vt[4] = '{n: 3'd4, p: {8'd255, 8'd255, 8'd255, 8'd255}, sum: 16'd1020, cnt: 5'd4, ovf: 1'b0};
        vt[5] = '{n: 3'd3, p: {8'd0,   8'd3,   8'd2,   8'd1},   sum: 16'd6,    cnt: 5'd3, ovf: 1'b0};

        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("reset_out_valid_d%0d", d), ov[d], 0);
            check($sformatf("reset_in_ready_d%0d", d), ir[d], 1);
            check($sformatf("reset_sum_d%0d", d), osum[d], 0);
            check($sformatf("reset_count_d%0d", d), ocnt[d], 0);
            check($sformatf("reset_ovf_d%0d", d), oovf[d], 0);
        end
        check("reset_state_d0", dbg0, IDLE);
        check("reset_state_d1", dbg1, IDLE);

        // Table vectors on the default instance (T1 is entry 0)
        for (int i = 0; i < NV; i++) begin
            for (int b = 0; b < int'(vt[i].n); b++) begin
                send_beat(0, vt[i].p[b], (b == int'(vt[i].n) - 1));
            end
            check($sformatf("vec%0d_latency", i), ov[0], 1);
            check($sformatf("vec%0d_in_ready_hold", i), ir[0], 0);
            expect_out(0, $sformatf("vec%0d", i), vt[i].sum, vt[i].cnt, vt[i].ovf);
        end

        // T2: MAX_TERMS close without in_last, then a fresh transaction
        for (int b = 0; b < 16; b++) send_beat(0, 8'd1, 1'b0);
        check("t2_close_valid", ov[0], 1);
        expect_out(0, "t2", 16, 16, 0);
        send_beat(0, 8'd7, 1'b1);
        expect_out(0, "t2_next", 7, 1, 0);

        // T4: backpressure with a waiting beat
        send_beat(0, 8'd9, 1'b1);
        iv[0] = 1'b1; pr[0] = 8'd4; il[0] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            check("t4_in_ready", ir[0], 0);
            check("t4_sum_stable", osum[0], 9);
            check("t4_valid_held", ov[0], 1);
            @(posedge clk);
            #1;
        end
        ordy[0] = 1'b1;
        @(posedge clk);
        #1;
        ordy[0] = 1'b0;
        check("t4_in_ready_after", ir[0], 1);
        check("t4_valid_dropped", ov[0], 0);
        @(posedge clk);
        #1;
        iv[0] = 1'b0; il[0] = 1'b0;
        check("t4_next_accepted", ov[0], 1);
        expect_out(0, "t4_next", 4, 1, 0);

        // T5: reset mid-transaction
        send_beat(0, 8'd7, 1'b0);
        send_beat(0, 8'd8, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("t5_out_valid", ov[0], 0);
        check("t5_count_cleared", ocnt[0], 0);
        check("t5_sum_cleared", osum[0], 0);
        send_beat(0, 8'd3, 1'b1);
        expect_out(0, "t5", 3, 1, 0);

        // T6: idle gap inside a transaction
        send_beat(0, 8'd10, 1'b0);
        spurious = 1'b0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (ov[0]) spurious = 1'b1;
        end
        check("t6_no_spurious", spurious, 0);
        send_beat(0, 8'd20, 1'b1);
        expect_out(0, "t6", 30, 2, 0);

        // T3 / T3s: 8-bit accumulator overflow
`ifdef MULT_ACC_SAT_EN
        send_beat(1, 8'd200, 1'b0);
        send_beat(1, 8'd100, 1'b0);
        send_beat(1, 8'd5, 1'b1);
        expect_out(1, "t3s", 255, 3, 1);
        for (int b = 0; b < 4; b++) send_beat(1, 8'd100, 1'b0);
        expect_out(1, "ovf4", 255, 4, 1);
`else
        send_beat(1, 8'd200, 1'b0);
        send_beat(1, 8'd100, 1'b1);
        expect_out(1, "t3", 44, 2, 1);
        for (int b = 0; b < 4; b++) send_beat(1, 8'd100, 1'b0);
        expect_out(1, "ovf4", 144, 4, 1);
`endif
        // Overflow flag does not leak into the next transaction
        for (int b = 0; b < 4; b++) send_beat(1, 8'd10, 1'b0);
        expect_out(1, "max4_close", 40, 4, 0);

        // Reset while holding a result
        send_beat(1, 8'd5, 1'b1);
        check("hold_rst_valid_before", ov[1], 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("hold_rst_valid_after", ov[1], 0);
        check("hold_rst_in_ready", ir[1], 1);

        // Randomized traffic, checked by the scoreboard
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 400; k++) begin
                @(negedge clk);
                a = iv[d] && ir[d];
                @(posedge clk);
                #1;
                if (!iv[d] || a) begin
                    iv[d] = ($urandom_range(0, 3) != 0);
                    pr[d] = 8'($urandom_range(0, 255));
                    il[d] = ($urandom_range(0, 5) == 0);
                end
                ordy[d] = ($urandom_range(0, 2) != 0);
            end
            iv[d] = 1'b0;
            il[d] = 1'b0;
            ordy[d] = 1'b1;
            repeat (5) @(posedge clk);
            #1;
            ordy[d] = 1'b0;
        end
        check("drain_q0", exp_q0.size(), 0);
        check("drain_q1", exp_q1.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
